program_memory_loader: RTL and testbench
========================================

# program_memory_loader

Loads a program image into the writable instruction memory from an 8-bit valid/ready byte stream. It sits between the host link and the program memory's write port, and is the write-side counterpart of the combinational instruction read path. Bytes are assembled into big-endian 32-bit words and written to consecutive word-aligned addresses. The processor is held in reset until a complete image has been written.

## Interface
- MEMORY_DEPTH, 32, number of instruction words the memory holds
- DATA_WIDTH, 32, instruction and address width (fixed at 32 for this block)
- BASE_ADDRESS, 32'h0040_0000, byte address of instruction word 0
- clk  input  1  single clock, rising-edge
- reset  input  1  asynchronous, active-high
- Start  input  1  one-cycle request to begin a load
- Length  input  16  words to load, sampled when Start is accepted
- ByteIn  input  8  stream byte
- ByteValid  input  1  ByteIn is valid
- ByteReady  output  1  loader accepts a byte this cycle
- WriteEnable  output  1  one-cycle memory write strobe
- WriteAddress  output  DATA_WIDTH  byte address of the word being written
- WriteData  output  DATA_WIDTH  assembled instruction word
- Busy  output  1  load in progress
- Done  output  1  image complete; held until the next accepted Start
- Error  output  1  rejected Length; held until the next accepted Start
- CpuReset  output  1  processor reset request

## Operation
- States: IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE: ByteReady=0 and ByteValid is ignored. On Start=1:
  - Length=0 or Length>MEMORY_DEPTH -> ERROR.
  - Otherwise latch Length, clear the word index and byte count -> COLLECT.
- COLLECT: ByteReady=1. A byte transfers when ByteValid&&ByteReady are high at a rising edge.
  - The first byte of a word goes to WriteData[31:24], then [23:16], [15:8], [7:0].
  - After the 4th transfer -> WRITE.
- WRITE: WriteEnable=1 and ByteReady=0 for exactly one cycle.
  - WriteAddress = BASE_ADDRESS + 4*index, so bits [1:0] are always 00.
  - Then index increments. If index+1 == Length -> DONE, else -> COLLECT.
- DONE: Done=1, CpuReset=0. Start re-validates Length and reloads.
- ERROR: Error=1, CpuReset=1. Start behaves as in IDLE.
- Start is ignored in COLLECT and WRITE.
- Busy=1 exactly in COLLECT and WRITE.
- CpuReset=1 in every state except DONE.
- Index arithmetic uses 16 bits. The address is computed in DATA_WIDTH bits and wraps modulo 2^32.
- WriteData and WriteAddress are registered and stable throughout the WRITE cycle.

## Timing
- Reset values: ByteReady=0, WriteEnable=0, WriteAddress=BASE_ADDRESS, WriteData=0, Busy=0, Done=0, Error=0, CpuReset=1, state=IDLE.
- Start accepted at edge N -> ByteReady=1 from cycle N+1.
- WriteEnable asserts in the cycle after the edge that accepts the 4th byte of a word.
- Minimum 5 cycles per word: 4 byte transfers plus 1 write.
- Gaps in ByteValid stall the loader indefinitely with no timeout; the partial word is retained.
- Done and CpuReset fall change in the cycle after the last WRITE.
- reset asserted mid-load: all outputs return to reset values immediately, without waiting for a clock edge. The partial word and index are discarded. Memory contents already written are not touched.
- Start coincident with ByteValid in IDLE: that byte is not consumed.

## Test plan
- Reset then Start, Length=1, bytes 20,08,00,05 back-to-back:
  - one WriteEnable pulse with WriteAddress=32'h0040_0000 and WriteData=32'h2008_0005.
  - Then Done=1, CpuReset=0.
- Length=3, ByteValid toggling every other cycle:
  - writes to 0x00400000, 0x00400004, 0x00400008 in order.
  - No WriteEnable while a word is incomplete; Busy=1 throughout.
- Length=0, then separately Length=MEMORY_DEPTH+1:
  - Error=1, ByteReady stays 0, no writes.
  - A following Start with Length=2 clears Error and loads normally.
- Length=MEMORY_DEPTH at full rate:
  - exactly 32 writes, the last at 0x0040007C.
  - Load completes in 160 cycles after Start acceptance.
- Assert reset after 2 bytes of word 1 (index 1) in a Length=4 load:
  - outputs are at reset values before the next edge.
  - A fresh Start restarts at 0x00400000 with no stale bytes.
- Start pulsed during COLLECT and during DONE:
  - ignored in COLLECT.
  - In DONE, restarts the load with Done=0 and CpuReset=1 on the next cycle.

Source files
------------

// File: rtl/program_memory_loader_if.sv
// Byte-stream input, memory write port and load status of the program memory loader.
interface program_memory_loader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [15:0]           length;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  cpu_reset;

  modport master (
    output start, length, byte_in, byte_valid,
    input  byte_ready, write_enable, write_address, write_data,
    input  busy, done, error, cpu_reset
  );

  modport slave (
    input  start, length, byte_in, byte_valid,
    output byte_ready, write_enable, write_address, write_data,
    output busy, done, error, cpu_reset
  );
endinterface

// File: rtl/program_memory_loader.sv
// Assembles a big-endian byte stream into 32-bit words, writes them to consecutive
// instruction addresses and holds the CPU in reset until the whole image is loaded.
module program_memory_loader #(
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
  input logic                    clk_i,
  input logic                    reset_i,
  program_memory_loader_if.slave bus_if
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  localparam logic [15:0] DEPTH_16 = 16'(MEMORY_DEPTH);

  logic [2:0]            state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_reset_q, cpu_reset_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus_if.start) begin
          if ((bus_if.length == 16'd0) || (bus_if.length > DEPTH_16)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_COLLECT;
            len_d   = bus_if.length;
            idx_d   = 16'd0;
            cnt_d   = 2'd0;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_COLLECT: begin
        // Shifting left leaves the first byte of the word in the top lane.
        if (bus_if.byte_valid && byte_ready_q) begin
          data_d = {data_q[DATA_WIDTH-9:0], bus_if.byte_in};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 16'd1;
        if ((idx_q + 16'd1) == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    addr_d       = BASE_ADDRESS + (DATA_WIDTH'(idx_d) << 2);
    byte_ready_d = (state_d == S_COLLECT);
    we_d         = (state_d == S_WRITE);
    busy_d       = (state_d == S_COLLECT) || (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
    cpu_reset_d  = (state_d != S_DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      len_q        <= 16'd0;
      idx_q        <= 16'd0;
      cnt_q        <= 2'd0;
      data_q       <= '0;
      addr_q       <= BASE_ADDRESS;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_reset_q  <= cpu_reset_d;
    end
  end

  assign bus_if.byte_ready    = byte_ready_q;
  assign bus_if.write_enable  = we_q;
  assign bus_if.write_address = addr_q;
  assign bus_if.write_data    = data_q;
  assign bus_if.busy          = busy_q;
  assign bus_if.done          = done_q;
  assign bus_if.error         = error_q;
  assign bus_if.cpu_reset     = cpu_reset_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader: reset values, loads, length rejection,
// stalls, mid-load reset and Start handling in each state.
module tb_program_memory_loader;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   c0       = 0;
  int   n0       = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  program_memory_loader_if #(.DATA_WIDTH(32)) bus ();

  program_memory_loader #(
    .MEMORY_DEPTH(32),
    .DATA_WIDTH  (32),
    .BASE_ADDRESS(32'h0040_0000)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus_if (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      wr_addr_q.push_back(bus.write_address);
      wr_data_q.push_back(bus.write_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start(input logic [15:0] len);
    bus.start  = 1'b1;
    bus.length = len;
    step();
    bus.start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_ready();
    int n = 0;
    while ((bus.byte_ready !== 1'b1) && (n < 20)) begin
      step();
      n++;
    end
    check("ready_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    wait_ready();
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    step();
    bus.byte_valid = 1'b0;
    check("busy_in_load", 32'(bus.busy), 32'd1);
    if (gap) step();
  endtask

  task automatic load_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], gap);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_we"},         32'(bus.write_enable), 32'd0);
    check({tag, "_addr"},       bus.write_address, 32'h0040_0000);
    check({tag, "_data"},       bus.write_data, 32'h0000_0000);
    check({tag, "_busy"},       32'(bus.busy), 32'd0);
    check({tag, "_done"},       32'(bus.done), 32'd0);
    check({tag, "_error"},      32'(bus.error), 32'd0);
    check({tag, "_cpu_reset"},  32'(bus.cpu_reset), 32'd1);
  endtask

  initial begin
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.length     = 16'd0;
    bus.byte_in    = 8'd0;
    bus.byte_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word; the byte offered together with Start must not be consumed.
    bus.byte_in    = 8'hFF;
    bus.byte_valid = 1'b1;
    send_start(16'd1);
    bus.byte_valid = 1'b0;
    check("l1_ready", 32'(bus.byte_ready), 32'd1);
    check("l1_busy", 32'(bus.busy), 32'd1);
    n0 = wr_addr_q.size();
    load_word(32'h2008_0005, 1'b0);
    check("l1_we", 32'(bus.write_enable), 32'd1);
    check("l1_addr", bus.write_address, 32'h0040_0000);
    check("l1_data", bus.write_data, 32'h2008_0005);
    step();
    check("l1_done", 32'(bus.done), 32'd1);
    check("l1_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("l1_busy_end", 32'(bus.busy), 32'd0);
    check("l1_we_end", 32'(bus.write_enable), 32'd0);
    check("l1_nwrites", 32'(wr_addr_q.size() - n0), 32'd1);

    // Three words with ByteValid toggling every other cycle.
    send_start(16'd3);
    n0 = wr_addr_q.size();
    load_word(32'h1122_3344, 1'b1);
    load_word(32'h5566_7788, 1'b1);
    load_word(32'h99AA_BBCC, 1'b1);
    step();
    check("l3_done", 32'(bus.done), 32'd1);
    check("l3_nwrites", 32'(wr_addr_q.size() - n0), 32'd3);
    if (wr_addr_q.size() - n0 == 3) begin
      check("l3_addr0", wr_addr_q[n0],   32'h0040_0000);
      check("l3_addr1", wr_addr_q[n0+1], 32'h0040_0004);
      check("l3_addr2", wr_addr_q[n0+2], 32'h0040_0008);
      check("l3_data0", wr_data_q[n0],   32'h1122_3344);
      check("l3_data1", wr_data_q[n0+1], 32'h5566_7788);
      check("l3_data2", wr_data_q[n0+2], 32'h99AA_BBCC);
    end

    // Rejected lengths.
    n0 = wr_addr_q.size();
    send_start(16'd0);
    check("e0_error", 32'(bus.error), 32'd1);
    check("e0_done", 32'(bus.done), 32'd0);
    check("e0_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("e0_busy", 32'(bus.busy), 32'd0);
    bus.byte_valid = 1'b1;
    step();
    step();
    step();
    check("e0_ready", 32'(bus.byte_ready), 32'd0);
    bus.byte_valid = 1'b0;
    send_start(16'd33);
    check("e33_error", 32'(bus.error), 32'd1);
    check("e33_ready", 32'(bus.byte_ready), 32'd0);
    check("e_nwrites", 32'(wr_addr_q.size() - n0), 32'd0);
    send_start(16'd2);
    check("e2_error_clr", 32'(bus.error), 32'd0);
    check("e2_ready", 32'(bus.byte_ready), 32'd1);
    load_word(32'hCAFE_0001, 1'b0);
    load_word(32'hCAFE_0002, 1'b0);
    step();
    check("e2_done", 32'(bus.done), 32'd1);
    check("e2_nwrites", 32'(wr_addr_q.size() - n0), 32'd2);
    if (wr_addr_q.size() - n0 == 2) begin
      check("e2_addr1", wr_addr_q[n0+1], 32'h0040_0004);
      check("e2_data1", wr_data_q[n0+1], 32'hCAFE_0002);
    end

    // Full memory at full rate: 5 cycles per word.
    send_start(16'd32);
    n0 = wr_addr_q.size();
    for (int i = 0; i < 32; i++) begin
      load_word(32'hA000_0000 | 32'(i), 1'b0);
    end
    step();
    check("full_done", 32'(bus.done), 32'd1);
    check("full_cycles", 32'(cyc - c0), 32'd160);
    check("full_nwrites", 32'(wr_addr_q.size() - n0), 32'd32);
    if (wr_addr_q.size() - n0 == 32) begin
      for (int i = 0; i < 32; i++) begin
        check("full_addr", wr_addr_q[n0+i], 32'h0040_0000 + 32'(4*i));
        check("full_data", wr_data_q[n0+i], 32'hA000_0000 | 32'(i));
      end
    end

    // Reset in the middle of word 1.
    send_start(16'd4);
    n0 = wr_addr_q.size();
    load_word(32'h0102_0304, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    #1 rst = 1'b0;
    step();
    check("midrst_nwrites", 32'(wr_addr_q.size() - n0), 32'd1);
    send_start(16'd1);
    load_word(32'hDEAD_BEEF, 1'b0);
    check("midrst_addr", bus.write_address, 32'h0040_0000);
    check("midrst_data", bus.write_data, 32'hDEAD_BEEF);
    step();
    check("midrst_done", 32'(bus.done), 32'd1);

    // Start during COLLECT is ignored.
    send_start(16'd2);
    n0 = wr_addr_q.size();
    send_byte(8'h12, 1'b0);
    bus.start  = 1'b1;
    bus.length = 16'd1;
    step();
    bus.start = 1'b0;
    check("sc_busy", 32'(bus.busy), 32'd1);
    check("sc_error", 32'(bus.error), 32'd0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    check("sc_data", bus.write_data, 32'h1234_5678);
    step();
    check("sc_not_done", 32'(bus.done), 32'd0);
    check("sc_still_busy", 32'(bus.busy), 32'd1);
    load_word(32'h9ABC_DEF0, 1'b0);
    step();
    check("sc_done", 32'(bus.done), 32'd1);
    check("sc_nwrites", 32'(wr_addr_q.size() - n0), 32'd2);

    // Start during DONE reloads.
    send_start(16'd1);
    check("sd_done", 32'(bus.done), 32'd0);
    check("sd_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("sd_busy", 32'(bus.busy), 32'd1);
    check("sd_ready", 32'(bus.byte_ready), 32'd1);
    load_word(32'h0BAD_F00D, 1'b0);
    check("sd_addr", bus.write_address, 32'h0040_0000);
    step();
    check("sd_done_end", 32'(bus.done), 32'd1);
    check("sd_cpu_reset_end", 32'(bus.cpu_reset), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
